// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake between a word producer and the UART transmit FIFO.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (output tx_valid, output tx_data, input  tx_ready);
    modport slave  (input  tx_valid, input  tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; frames run back-to-back while words are queued.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 5625,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_tx_fifo_if.slave               tx_if,
    output logic                        tx_out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic [TW-1:0]        timer;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 parity_bit;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [LW-1:0]        count;

    logic                 push;
    logic                 pop;
    logic                 timer_done;
    logic                 last_stop;
    logic [DATA_BITS-1:0] head;

    assign tx_if.tx_ready = (count != LW'(FIFO_DEPTH));
    assign push           = tx_if.tx_valid && tx_if.tx_ready;
    assign timer_done     = (timer == TW'(CLKS_PER_BIT - 1));
    assign last_stop      = (STOP_BITS == 1) || stop_idx;
    assign head           = mem[rd_ptr];
    assign fifo_level     = count;

    // A pop happens from IDLE, or at the very end of the last stop bit so frames abut.
    assign pop = (count != '0) &&
                 ((state == S_IDLE) || ((state == S_STOP) && timer_done && last_stop));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_if.tx_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + LW'(push) - LW'(pop);
        end
    end

    // Parity is latched with the word at pop time so the shifting data can be consumed freely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shift      <= '0;
            parity_bit <= 1'b0;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
        end else if (pop) begin
            state      <= S_START;
            timer      <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shift      <= head;
            parity_bit <= (^head) ^ (PARITY == 1);
            tx_out     <= 1'b0;
            busy       <= 1'b1;
        end else begin
            if (state != S_IDLE) begin
                timer <= timer_done ? '0 : timer + TW'(1);
            end
            if (timer_done) begin
                case (state)
                    S_START: begin
                        state  <= S_DATA;
                        tx_out <= shift[0];
                    end
                    S_DATA: begin
                        if (bit_idx == BW'(DATA_BITS - 1)) begin
                            stop_idx <= 1'b0;
                            if (PARITY != 0) begin
                                state  <= S_PARITY;
                                tx_out <= parity_bit;
                            end else begin
                                state  <= S_STOP;
                                tx_out <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                            shift   <= shift >> 1;
                            tx_out  <= shift[1];
                        end
                    end
                    S_PARITY: begin
                        state    <= S_STOP;
                        stop_idx <= 1'b0;
                        tx_out   <= 1'b1;
                    end
                    S_STOP: begin
                        if (last_stop) begin
                            state  <= S_IDLE;
                            busy   <= 1'b0;
                            tx_out <= 1'b1;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= S_IDLE;
                        busy   <= 1'b0;
                        tx_out <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 5625, clk cycles per serial bit (54 MHz / 9600 baud); legal range 2..65535.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 The block SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1, 2.
REQ-005 The block SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, 2..64.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 tx_valid  input  1  write request; a word is accepted on a rising edge where tx_valid=1 and tx_ready=1.
REQ-009 tx_data  input  DATA_BITS  word to transmit, sampled on acceptance.
REQ-010 tx_ready  output  1  high when the FIFO is not full.
REQ-011 tx_out  output  1  serial line, idle high.
REQ-012 busy  output  1  high while a frame is on the line (any state other than IDLE).
REQ-013 fifo_level  output  clog2(FIFO_DEPTH)+1  number of words held in the FIFO, excluding the frame being shifted.

Function
REQ-014 The FIFO SHALL be first-in-first-out; a push with tx_ready=0 SHALL be ignored with no state change.
REQ-015 A push and a pop on the same edge SHALL leave fifo_level unchanged and SHALL preserve word order.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-017 In IDLE with fifo_level>0, the FSM SHALL pop the head word into a shift register and enter START on the same edge.
REQ-018 A push into an empty FIFO while in IDLE SHALL cause tx_out=0 to appear one cycle after the accepting edge.
REQ-019 A bit timer SHALL restart at 0 on each entry to START; each line bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-020 START SHALL drive 0; DATA SHALL drive tx_data LSB first for DATA_BITS bits; PARITY (skipped when PARITY=0) SHALL drive the XOR of the data bits for even, its inverse for odd; STOP SHALL drive 1 for STOP_BITS bit periods.
REQ-021 Frame length SHALL equal (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
REQ-022 At the end of the last stop bit, with fifo_level>0, the FSM SHALL pop and enter START on that edge (no idle gap); otherwise it SHALL enter IDLE.
REQ-023 Changes to tx_data or tx_valid after acceptance SHALL NOT affect a frame in progress.
REQ-024 The bit timer and bit counters SHALL never wrap outside their defined ranges; no state other than the five listed SHALL be reachable.
REQ-025 tx_out SHALL be driven from a register (glitch-free).

Reset
REQ-026 While reset=0: tx_out=1, busy=0, tx_ready=1, fifo_level=0, FSM=IDLE, bit timer=0, FIFO pointers=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately, drive tx_out=1 asynchronously, and discard all FIFO contents.
REQ-028 After reset deasserts, no frame SHALL start until a new word is accepted.

Verification
REQ-029 CLKS_PER_BIT=4, defaults otherwise; push 0xA5 once -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, start bit one cycle after push; busy high 40 cycles.
REQ-030 PARITY=2, push 0x07 -> parity bit 1; PARITY=1, push 0x07 -> parity bit 0; frame 44 cycles at CLKS_PER_BIT=4.
REQ-031 FIFO_DEPTH=4, push 6 words back-to-back at idle -> first popped immediately, tx_ready=0 after 5th accepted word, 6th held until ready rises; all 6 frames emitted in order with no idle cycles between them.
REQ-032 STOP_BITS=2, DATA_BITS=7, push 0x7F -> 10 bit periods, last two bits 1, next frame start no earlier than end of second stop bit.
REQ-033 Assert reset during DATA bit 3 with 2 words queued -> tx_out=1 and fifo_level=0 in the same cycle; no further frames after release.
REQ-034 Push while full with tx_valid held -> fifo_level stays at FIFO_DEPTH, no word dropped or duplicated in output stream.
